// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Services a cache miss by reading one block from a pipelined main memory,
//   one 16-bit word per request. Each returned word goes to the data array
//   in arrival order. The tag array is written on the last word.
// Ports
//   clk, rst           : clock; synchronous active-high reset
//   miss_detected      : miss request, sampled only while idle
//   miss_address       : byte address of the missing access
//   memory_data/_valid : memory read return (in request order)
//   fsm_busy           : fill in progress (pipeline stall)
//   mem_read_en        : memory read request this cycle
//   memory_address     : word-aligned byte address of the request (0 when idle)
//   write_data_array   : write cache_data into word data_array_word
//   data_array_word    : response index within the block
//   cache_data         : pass-through of memory_data
//   write_tag_array    : one-cycle tag/valid write for the latched block
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [15:0]                    miss_address,
  input  logic [15:0]                    memory_data,
  input  logic                           memory_data_valid,
  output logic                           fsm_busy,
  output logic                           mem_read_en,
  output logic [15:0]                    memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] data_array_word,
  output logic [15:0]                    cache_data,
  output logic                           write_tag_array
);
  localparam int OFF_BITS = $clog2(BLOCK_WORDS);
  localparam int BLK_BITS = 15 - OFF_BITS;
  localparam logic [OFF_BITS:0]   REQ_END  = (OFF_BITS+1)'(BLOCK_WORDS);
  localparam logic [OFF_BITS-1:0] RSP_LAST = OFF_BITS'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t              r_state;
  logic [BLK_BITS-1:0] r_blk_addr;
  logic [OFF_BITS:0]   r_req_cnt;  // extra bit marks "all requests issued"
  logic [OFF_BITS-1:0] r_rsp_cnt;

  logic w_fill, w_rd_en, w_rsp, w_last;

  // Byte-offset bits of the miss address select nothing inside a block fill.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = &{1'b0, miss_address[OFF_BITS:0]};

  assign w_fill  = (r_state == FILL);
  assign w_rd_en = w_fill && (r_req_cnt < REQ_END);
  assign w_rsp   = w_fill && memory_data_valid;  // valids outside a fill are stale
  assign w_last  = w_rsp && (r_rsp_cnt == RSP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_blk_addr <= '0;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_detected) begin
            r_blk_addr <= miss_address[15:OFF_BITS+1];
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (w_rd_en) r_req_cnt <= r_req_cnt + 1'b1;
          if (w_rsp)   r_rsp_cnt <= r_rsp_cnt + 1'b1;  // wraps to 0 on the last word
          if (w_last)  r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fsm_busy         = w_fill;
  assign mem_read_en      = w_rd_en;
  assign memory_address   = w_rd_en ? {r_blk_addr, r_req_cnt[OFF_BITS-1:0], 1'b0} : 16'h0000;
  assign write_data_array = w_rsp;
  assign data_array_word  = r_rsp_cnt;
  assign cache_data       = memory_data;
  assign write_tag_array  = w_last;
endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst, miss_detected, memory_data_valid;
  logic [15:0] miss_address, memory_data;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_data;
  logic [2:0]  data_array_word;

  cache_fill_fsm #(.BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .data_array_word(data_array_word),
    .cache_data(cache_data), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int cyc = 0;

  // Transaction-level model: a fill is (start cycle, block base, responses seen).
  logic        m_busy = 1'b0;
  int          m_start = 0, m_rsp = 0;
  logic [15:0] m_base = 16'h0;

  // Memory model: FIFO of (due cycle, data); order preserved.
  int          q_due[$];
  logic [15:0] q_data[$];
  int          last_due = 0;
  int          lat_lo = 4, lat_hi = 4;
  logic        dmode = 1'b0, noise_en = 1'b0;

  // Observations and model expectations of the last checked cycle.
  logic        obs_busy, obs_rd, obs_wr, obs_tag;
  logic [15:0] obs_addr, obs_cd, exp_addr;
  logic [2:0]  obs_idx;
  int          tag_cnt = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    int          off, lat, due;
    logic        e_rd, e_wr, e_tag, v;
    logic [15:0] e_addr, d;
    logic [2:0]  e_idx;
    @(negedge clk);
    off    = cyc - m_start;
    e_rd   = m_busy && off >= 0 && off < BW;
    e_addr = e_rd ? m_base + 16'(2 * off) : 16'h0000;
    e_wr   = m_busy && memory_data_valid;
    e_idx  = 3'(m_rsp % BW);
    e_tag  = e_wr && (m_rsp == BW - 1);
    exp_addr = e_addr;
    obs_busy = fsm_busy; obs_rd = mem_read_en; obs_addr = memory_address;
    obs_wr = write_data_array; obs_idx = data_array_word; obs_cd = cache_data;
    obs_tag = write_tag_array;
    if (obs_tag) tag_cnt++;
    if (obs_rd)  rd_cnt++;
    if (obs_wr)  wr_cnt++;
    chk("busy",  {15'b0, fsm_busy},         {15'b0, m_busy});
    chk("rd_en", {15'b0, mem_read_en},      {15'b0, e_rd});
    chk("addr",  memory_address,            e_addr);
    chk("wr",    {15'b0, write_data_array}, {15'b0, e_wr});
    chk("idx",   {13'b0, data_array_word},  {13'b0, e_idx});
    chk("data",  cache_data,                memory_data);
    chk("tag",   {15'b0, write_tag_array},  {15'b0, e_tag});
    // memory accepts every issued request, even one issued in a reset cycle
    if (e_rd) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_due.push_back(due);
      q_data.push_back(dmode ? 16'hA000 + 16'(off) : 16'($urandom));
    end
    if (rst) begin
      m_busy = 1'b0; m_rsp = 0;
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_busy = 1'b1; m_start = cyc + 1; m_rsp = 0;
        m_base = miss_address & ~16'(2 * BW - 1);
      end
    end else if (memory_data_valid) begin
      m_rsp++;
      if (m_rsp == BW) begin m_busy = 1'b0; m_rsp = 0; end
    end
    @(posedge clk);
    #1;
    cyc++;
    v = 1'b0; d = 16'($urandom);
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      v = 1'b1; d = q_data[0];
      void'(q_due.pop_front()); void'(q_data.pop_front());
    end else if (noise_en) v = 1'($urandom_range(1, 0));
    memory_data_valid = v; memory_data = d;
  endtask

  task automatic start_fill(input logic [15:0] a, input int lo, input int hi, input logic dm);
    lat_lo = lo; lat_hi = hi; dmode = dm;
    miss_address = a; miss_detected = 1'b1;
    step();  // cycle 0
    miss_detected = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    miss_detected = 1'b0; rst = 1'b0;
    while ((m_busy || q_due.size() > 0) && n < 100) begin step(); n++; end
    if (n >= 100) begin
      fails++;
      $display("FAIL drain_timeout cyc=%0d actual=busy expected=idle", cyc);
    end
    step();
  endtask

  initial begin
    int t0, r0, b, k;
    logic inj;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data = 16'h0;
    step(); step();
    chk("reset_busy", {15'b0, obs_busy}, 16'h0);
    chk("reset_addr", obs_addr, 16'h0);
    rst = 1'b0;

    // idle with noisy valid strobes
    noise_en = 1'b1; t0 = wr_cnt;
    repeat (5) step();
    noise_en = 1'b0;
    chk("idle_no_writes", 16'(wr_cnt - t0), 16'd0);
    step();

    // directed fill, 4-cycle memory, data A000+i
    t0 = tag_cnt; b = 0;
    start_fill(16'h1236, 4, 4, 1'b1);
    for (int r = 1; r <= 13; r++) begin
      step();
      if (obs_busy) b++;
      if (r == 1) begin
        chk("d_addr1", obs_addr, 16'h1230);
        chk("model_addr1", exp_addr, 16'h1230);
      end
      if (r == 8)  chk("d_addr8", obs_addr, 16'h123E);
      if (r == 9)  chk("d_rd_off9", {15'b0, obs_rd}, 16'h0);
      if (r == 5)  begin chk("d_wr5", {15'b0, obs_wr}, 16'h1); chk("d_cd5", obs_cd, 16'hA000); end
      if (r == 11) chk("d_tag11", {15'b0, obs_tag}, 16'h0);
      if (r == 12) begin
        chk("d_tag12", {15'b0, obs_tag}, 16'h1);
        chk("d_idx12", {13'b0, obs_idx}, 16'd7);
        chk("d_cd12", obs_cd, 16'hA007);
      end
      if (r == 13) chk("d_busy13", {15'b0, obs_busy}, 16'h0);
    end
    chk("d_busy_cycles", 16'(b), 16'd12);
    chk("d_one_tag", 16'(tag_cnt - t0), 16'd1);
    drain();

    // miss pulses during a fill are ignored
    t0 = tag_cnt; r0 = rd_cnt;
    start_fill(16'h0842, 4, 4, 1'b0);
    for (int r = 1; r <= 13; r++) begin
      miss_detected = (r == 3 || r == 10);
      miss_address = 16'h7770;
      step();
    end
    miss_detected = 1'b0;
    drain();
    chk("p_requests", 16'(rd_cnt - r0), 16'd8);
    chk("p_tags", 16'(tag_cnt - t0), 16'd1);

    // miss held across completion starts the next fill at cycle 14
    start_fill(16'h2002, 4, 4, 1'b0);
    for (int r = 1; r <= 14; r++) begin
      if (r == 12) begin miss_address = 16'h4446; miss_detected = 1'b1; end
      if (r == 14) miss_detected = 1'b0;
      step();
      if (r == 13) chk("h_busy13", {15'b0, obs_busy}, 16'h0);
      if (r == 14) begin
        chk("h_rd14", {15'b0, obs_rd}, 16'h1);
        chk("h_addr14", obs_addr, 16'h4440);
      end
    end
    drain();

    // reset in cycle 6 aborts the fill
    t0 = tag_cnt;
    start_fill(16'h3010, 4, 4, 1'b0);
    for (int r = 1; r <= 7; r++) begin
      rst = (r == 6);
      step();
    end
    chk("r_busy7", {15'b0, obs_busy}, 16'h0);
    chk("r_rd7", {15'b0, obs_rd}, 16'h0);
    chk("r_addr7", obs_addr, 16'h0);
    chk("r_idx7", {13'b0, obs_idx}, 16'h0);
    r0 = wr_cnt;
    drain();
    chk("r_trailing_writes", 16'(wr_cnt - r0), 16'd0);
    chk("r_no_tag", 16'(tag_cnt - t0), 16'd0);
    // reset and miss together: reset wins
    rst = 1'b1; miss_detected = 1'b1; step();
    rst = 1'b0; miss_detected = 1'b0; step();
    chk("rm_busy", {15'b0, obs_busy}, 16'h0);
    t0 = tag_cnt;
    start_fill(16'h5554, 4, 4, 1'b1);
    drain();
    chk("r_refill_tag", 16'(tag_cnt - t0), 16'd1);

    // top of address space with variable latency 4..7
    t0 = tag_cnt;
    start_fill(16'hFFF5, 4, 7, 1'b0);
    for (int r = 1; r <= 8; r++) step();
    chk("t_addr8", obs_addr, 16'hFFFE);
    drain();
    chk("t_tag", 16'(tag_cnt - t0), 16'd1);

    // randomized fills: addresses, latencies, ignored misses, occasional reset
    for (int n = 0; n < 30; n++) begin
      int r;
      t0 = tag_cnt;
      inj = ($urandom_range(3, 0) == 0);
      k = $urandom_range(8, 2);
      lat_lo = $urandom_range(4, 1);
      start_fill(16'($urandom), lat_lo, lat_lo + $urandom_range(3, 0), 1'b0);
      r = 1;
      while (m_busy && r < 60) begin
        miss_detected = ($urandom_range(3, 0) == 0);
        miss_address = 16'($urandom);
        rst = inj && (r == k);
        step();
        r++;
      end
      if (r >= 60) begin
        fails++;
        $display("FAIL rand_timeout cyc=%0d actual=busy expected=idle", cyc);
      end
      drain();
      chk("rand_tags", 16'(tag_cnt - t0), inj ? 16'd0 : 16'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
